// File: rtl/regfile_pkg.sv
// regfile_pkg: shared defaults and types for the regfile_sb register file.
// Optional same-cycle write-to-read forwarding in regfile_sb is enabled by
// defining the macro RF_BYPASS_EN.
package regfile_pkg;

  localparam int unsigned XLEN_DEF = 32;
  localparam int unsigned NREG_DEF = 32;

  // Address width needed to index n registers.
  function automatic int unsigned addrWidth(input int unsigned n);
    return $clog2(n);
  endfunction

  localparam int unsigned AW_DEF = addrWidth(NREG_DEF);

  typedef logic [AW_DEF-1:0]   reg_addr_t;
  typedef logic [XLEN_DEF-1:0] xdata_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: one busy bit per architectural register plus a
// registered population count. Register 0 is never marked busy.
// Not affected by RF_BYPASS_EN; forwarding lives in regfile_sb.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter  int unsigned NREG = NREG_DEF,
  localparam int unsigned AW   = addrWidth(NREG)
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            iss_valid_i,
  input  logic [AW-1:0]   iss_rd_addr_i,
  input  logic            wb_wren_i,
  input  logic [AW-1:0]   wb_addr_i,
  input  logic            flush_i,
  output logic [NREG-1:0] busy_o,
  output logic [AW:0]     busy_cnt_o
);

  logic [NREG-1:0] busyBits_q, busyBits_d;
  logic [AW:0]     busyCnt_q, busyCnt_d;

  // Next busy vector: flush wins over everything, and an issue applied after
  // a write-back clear lets the newer issue win on the same register.
  always_comb begin
    busyBits_d = busyBits_q;
    if (flush_i) begin
      busyBits_d = '0;
    end else begin
      if (wb_wren_i && (wb_addr_i != '0)) busyBits_d[wb_addr_i] = 1'b0;
      if (iss_valid_i && (iss_rd_addr_i != '0)) busyBits_d[iss_rd_addr_i] = 1'b1;
    end
    busyBits_d[0] = 1'b0;
  end

  // Count the next busy vector so the count register tracks the bits exactly.
  always_comb begin
    busyCnt_d = '0;
    for (int i = 0; i < int'(NREG); i++) begin
      busyCnt_d = busyCnt_d + (AW+1)'(busyBits_d[i]);
    end
  end

  // Busy bits and their count update together.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      busyBits_q <= '0;
      busyCnt_q  <= '0;
    end else begin
      busyBits_q <= busyBits_d;
      busyCnt_q  <= busyCnt_d;
    end
  end

  assign busy_o     = busyBits_q;
  assign busy_cnt_o = busyCnt_q;

endmodule

// File: rtl/regfile_sb.sv
// regfile_sb: integer register file with NRP combinational read ports, one
// write-back port and a write scoreboard for RAW hazard detection.
// Define RF_BYPASS_EN to forward write-back data to same-cycle reads.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter  int unsigned XLEN = XLEN_DEF,
  parameter  int unsigned NREG = NREG_DEF,
  parameter  int unsigned NRP  = 2,
  localparam int unsigned AW   = addrWidth(NREG)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [NRP*AW-1:0] rs_addr_i,
  output logic [NRP*XLEN-1:0] rs_data_o,
  output logic [NRP-1:0]    rs_busy_o,
  input  logic              iss_valid_i,
  input  logic [AW-1:0]     iss_rd_addr_i,
  input  logic              wb_wren_i,
  input  logic [AW-1:0]     wb_addr_i,
  input  logic [XLEN-1:0]   wb_data_i,
  input  logic              flush_i,
  output logic [AW:0]       busy_cnt_o
);

  logic [XLEN-1:0] regs_q [NREG];
  logic [NREG-1:0] busyVec;
  logic [AW-1:0]   rdAddr;

  regfile_scoreboard #(
    .NREG (NREG)
  ) u_scoreboard (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .iss_valid_i   (iss_valid_i),
    .iss_rd_addr_i (iss_rd_addr_i),
    .wb_wren_i     (wb_wren_i),
    .wb_addr_i     (wb_addr_i),
    .flush_i       (flush_i),
    .busy_o        (busyVec),
    .busy_cnt_o    (busy_cnt_o)
  );

  // Data array: register 0 is never written so it stays at its reset value 0.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(NREG); i++) regs_q[i] <= '0;
    end else if (wb_wren_i && (wb_addr_i != '0)) begin
      regs_q[wb_addr_i] <= wb_data_i;
    end
  end

  // Read muxes; address 0 reads as zero and never busy.
  always_comb begin
    rs_data_o = '0;
    rs_busy_o = '0;
    rdAddr    = '0;
    for (int k = 0; k < int'(NRP); k++) begin
      rdAddr = rs_addr_i[k*AW +: AW];
      if (rdAddr != '0) begin
`ifdef RF_BYPASS_EN
        if (rst_ni && wb_wren_i && (wb_addr_i == rdAddr)) begin
          rs_data_o[k*XLEN +: XLEN] = wb_data_i;
          rs_busy_o[k] = iss_valid_i && (iss_rd_addr_i == rdAddr) && !flush_i;
        end else begin
          rs_data_o[k*XLEN +: XLEN] = regs_q[rdAddr];
          rs_busy_o[k] = busyVec[rdAddr];
        end
`else
        rs_data_o[k*XLEN +: XLEN] = regs_q[rdAddr];
        rs_busy_o[k] = busyVec[rdAddr];
`endif
      end
    end
  end

endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: scoreboard bench for regfile_sb with a behavioural model.
// Honours RF_BYPASS_EN the same way the design does.
module tb_regfile_sb;
  import regfile_pkg::*;

  localparam int unsigned XLEN = XLEN_DEF;
  localparam int unsigned NREG = NREG_DEF;
  localparam int unsigned NRP  = 2;
  localparam int unsigned AW   = AW_DEF;

  logic                 clk_i = 1'b0;
  logic                 rst_ni;
  logic [NRP*AW-1:0]    rs_addr_i;
  logic [NRP*XLEN-1:0]  rs_data_o;
  logic [NRP-1:0]       rs_busy_o;
  logic                 iss_valid_i;
  reg_addr_t            iss_rd_addr_i;
  logic                 wb_wren_i;
  reg_addr_t            wb_addr_i;
  xdata_t               wb_data_i;
  logic                 flush_i;
  logic [AW:0]          busy_cnt_o;

  always #5 clk_i = ~clk_i;

  regfile_sb #(.XLEN(XLEN), .NREG(NREG), .NRP(NRP)) dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .rs_addr_i     (rs_addr_i),
    .rs_data_o     (rs_data_o),
    .rs_busy_o     (rs_busy_o),
    .iss_valid_i   (iss_valid_i),
    .iss_rd_addr_i (iss_rd_addr_i),
    .wb_wren_i     (wb_wren_i),
    .wb_addr_i     (wb_addr_i),
    .wb_data_i     (wb_data_i),
    .flush_i       (flush_i),
    .busy_cnt_o    (busy_cnt_o)
  );

  typedef struct {
    string               name;
    logic [NRP*XLEN-1:0] data;
    logic [NRP-1:0]      busy;
    logic [AW:0]         cnt;
  } exp_t;

  exp_t   expQ[$];
  xdata_t mReg [NREG];
  bit     mBusy [NREG];
  int     testsRun = 0;
  int     testsFailed = 0;

  // Number of registers the model currently considers busy.
  function automatic logic [AW:0] modelCount();
    int n = 0;
    for (int i = 0; i < int'(NREG); i++) if (mBusy[i]) n++;
    return n[AW:0];
  endfunction

  // What a read of register a must show right now, given the inputs driven.
  task automatic pushExpected(input string name);
    exp_t e;
    reg_addr_t a;
    e.name = name;
    e.data = '0;
    e.busy = '0;
    for (int k = 0; k < int'(NRP); k++) begin
      a = rs_addr_i[k*AW +: AW];
      if (rst_ni && a != 0) begin
        e.data[k*XLEN +: XLEN] = mReg[a];
        e.busy[k] = mBusy[a];
`ifdef RF_BYPASS_EN
        if (wb_wren_i && wb_addr_i == a) begin
          e.data[k*XLEN +: XLEN] = wb_data_i;
          e.busy[k] = iss_valid_i && iss_rd_addr_i == a && !flush_i;
        end
`endif
      end
    end
    e.cnt = rst_ni ? modelCount() : '0;
    expQ.push_back(e);
  endtask

  // Architectural effect of one clock edge.
  task automatic modelEdge();
    if (!rst_ni) return;
    if (wb_wren_i && wb_addr_i != 0) mReg[wb_addr_i] = wb_data_i;
    if (flush_i) begin
      for (int i = 0; i < int'(NREG); i++) mBusy[i] = 1'b0;
    end else begin
      if (wb_wren_i && wb_addr_i != 0) mBusy[wb_addr_i] = 1'b0;
      if (iss_valid_i && iss_rd_addr_i != 0) mBusy[iss_rd_addr_i] = 1'b1;
    end
  endtask

  task automatic modelReset();
    for (int i = 0; i < int'(NREG); i++) begin
      mReg[i]  = '0;
      mBusy[i] = 1'b0;
    end
  endtask

  task automatic checkOutput(input exp_t e);
    testsRun++;
    if (rs_data_o !== e.data) begin
      testsFailed++;
      $display("[TB] FAIL %s data: got %h expected %h", e.name, rs_data_o, e.data);
    end
    testsRun++;
    if (rs_busy_o !== e.busy) begin
      testsFailed++;
      $display("[TB] FAIL %s busy: got %b expected %b", e.name, rs_busy_o, e.busy);
    end
    testsRun++;
    if (busy_cnt_o !== e.cnt) begin
      testsFailed++;
      $display("[TB] FAIL %s count: got %0d expected %0d", e.name, busy_cnt_o, e.cnt);
    end
  endtask

  // One cycle: drive inputs after an edge, queue the expected read, take the edge.
  task automatic applyStimulus(input bit iss, input reg_addr_t issA, input bit wb,
                               input reg_addr_t wbA, input xdata_t wbD, input bit fl,
                               input reg_addr_t ra0, input reg_addr_t ra1, input string name);
    iss_valid_i   = iss;
    iss_rd_addr_i = issA;
    wb_wren_i     = wb;
    wb_addr_i     = wbA;
    wb_data_i     = wbD;
    flush_i       = fl;
    rs_addr_i     = {ra1, ra0};
    pushExpected(name);
    @(posedge clk_i);
    modelEdge();
    #1;
  endtask

  task automatic readOnly(input reg_addr_t ra0, input reg_addr_t ra1, input string name);
    applyStimulus(1'b0, '0, 1'b0, '0, '0, 1'b0, ra0, ra1, name);
  endtask

  // Monitor: compares the oldest queued expectation away from the active edge.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk_i);
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        checkOutput(e);
      end
    end
  end

  initial begin : stimulus
    reg_addr_t ra0, ra1, issA, wbA;
    int drain;
    rst_ni = 1'b0;
    iss_valid_i = 1'b0; iss_rd_addr_i = '0; wb_wren_i = 1'b0; wb_addr_i = '0;
    wb_data_i = '0; flush_i = 1'b0; rs_addr_i = '0;
    modelReset();
    repeat (2) @(posedge clk_i);
    #1;
    readOnly(5, 7, "inReset");
    rst_ni = 1'b1;

    // Write and read back, plus register 0 immunity.
    applyStimulus(0, 0, 1, 5, 32'hDEADBEEF, 0, 5, 5, "wbX5Same");
    readOnly(5, 5, "readX5");
    applyStimulus(0, 0, 1, 0, 32'h00001234, 0, 0, 5, "wbX0");
    readOnly(0, 0, "readX0");

    // Issue then write-back clears busy.
    applyStimulus(1, 7, 0, 0, 0, 0, 7, 0, "issX7");
    readOnly(7, 5, "x7Busy");
    applyStimulus(0, 0, 1, 7, 32'hA5A5A5A5, 0, 7, 7, "wbX7");
    readOnly(7, 0, "x7Clear");

    // Same-cycle issue and write-back: newer issue keeps busy.
    applyStimulus(1, 9, 0, 0, 0, 0, 9, 0, "issX9");
    applyStimulus(1, 9, 1, 9, 32'h0BADF00D, 0, 9, 7, "issWbX9");
    readOnly(9, 0, "x9StillBusy");
    applyStimulus(0, 0, 1, 9, 32'h11112222, 0, 9, 0, "wbX9");

    // Flush discards in-flight writes and ignores a concurrent issue.
    applyStimulus(1, 3, 0, 0, 0, 0, 3, 4, "issX3");
    applyStimulus(1, 4, 0, 0, 0, 0, 3, 4, "issX4");
    readOnly(3, 4, "count2");
    applyStimulus(1, 6, 1, 3, 32'h33333333, 1, 6, 3, "flushIssX6");
    readOnly(6, 3, "afterFlush");
    readOnly(4, 0, "afterFlush2");

    // Forwarding case: write-back while reading the same register.
    applyStimulus(0, 0, 1, 10, 32'h00000055, 0, 10, 5, "wbX10Read");
    readOnly(10, 0, "x10After");

    // Randomised traffic, biased to a small address set for collisions.
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(1, 0) == 1) begin
        issA = reg_addr_t'($urandom_range(7, 0));
        wbA  = reg_addr_t'($urandom_range(7, 0));
        ra0  = reg_addr_t'($urandom_range(7, 0));
        ra1  = reg_addr_t'($urandom_range(7, 0));
      end else begin
        issA = reg_addr_t'($urandom_range(NREG-1, 0));
        wbA  = reg_addr_t'($urandom_range(NREG-1, 0));
        ra0  = reg_addr_t'($urandom_range(NREG-1, 0));
        ra1  = reg_addr_t'($urandom_range(NREG-1, 0));
      end
      applyStimulus($urandom_range(1, 0) == 1, issA, $urandom_range(1, 0) == 1, wbA,
                    $urandom(), $urandom_range(19, 0) == 0, ra0, ra1, "random");
    end

    // Reset mid-run: outputs must clear without any clock edge.
    applyStimulus(0, 0, 1, 12, 32'hCAFEF00D, 0, 12, 0, "preReset1");
    applyStimulus(1, 13, 0, 0, 0, 0, 12, 13, "preReset2");
    wb_wren_i = 1'b0; iss_valid_i = 1'b0; flush_i = 1'b0;
    rs_addr_i = {reg_addr_t'(13), reg_addr_t'(12)};
    rst_ni = 1'b0;
    #1;
    modelReset();
    pushExpected("midReset");
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    readOnly(12, 13, "postReset");
    readOnly(5, 7, "postReset2");

    drain = 0;
    while (expQ.size() > 0 && drain < 10) begin
      @(posedge clk_i);
      drain++;
    end
    if (expQ.size() > 0) begin
      testsRun++;
      testsFailed++;
      $display("[TB] FAIL drain: %0d pending expected 0", expQ.size());
    end
    #1;
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
